// File: rtl/tff_updown_counter_if.sv
// Control and status bundle of the toggle-vector up/down counter.
// master drives the controls; slave is the counter itself.
interface tff_updown_counter_if #(
  parameter int WIDTH = 4
);
  logic             preset;
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qnot;
  logic [WIDTH-1:0] t_out;
  logic             tc;
  logic             wrap;
  logic             err;

  modport master (
    output preset, en, up, load, din,
    input  q, qnot, t_out, tc, wrap, err
  );

  modport slave (
    input  preset, en, up, load, din,
    output q, qnot, t_out, tc, wrap, err
  );
endinterface

// File: rtl/tff_updown_counter.sv
// Modulo-N up/down counter exposing its per-edge toggle vector.
// Define TFF_UPDOWN_SATURATE_EN to stop at the bounds instead of wrapping.
module tff_updown_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input logic clk,
  input logic clear,
  tff_updown_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX =
    WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] qnot_q;
  logic [WIDTH-1:0] cnt_nxt;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic             at_top, at_bot;
  logic             term, tc, in_rng;
  logic             wrap_cnt;
  logic             sel_clr, sel_pre;
  logic             sel_ld, sel_cnt;

  assign at_top = (q_q == MAX);
  assign at_bot = (q_q == '0);
  assign term   = bus.up ? at_top : at_bot;
  assign in_rng = {1'b0, bus.din} <
                  (WIDTH+1)'(MODULUS);

  // One-hot action select, priority resolved here
  assign sel_clr = ~clear;
  assign sel_pre = clear & ~bus.preset;
  assign sel_ld  = clear & bus.preset & bus.load;
  assign sel_cnt = clear & bus.preset &
                   ~bus.load & bus.en;

  assign tc = sel_cnt & term;

  always_comb begin
    cnt_nxt = q_q;
    if (bus.up) begin
`ifdef TFF_UPDOWN_SATURATE_EN
      cnt_nxt = at_top ? q_q : q_q + WIDTH'(1);
`else
      cnt_nxt = at_top ? '0 : q_q + WIDTH'(1);
`endif
    end else begin
`ifdef TFF_UPDOWN_SATURATE_EN
      cnt_nxt = at_bot ? q_q : q_q - WIDTH'(1);
`else
      cnt_nxt = at_bot ? MAX : q_q - WIDTH'(1);
`endif
    end
  end

`ifdef TFF_UPDOWN_SATURATE_EN
  assign wrap_cnt = 1'b0;
`else
  assign wrap_cnt = tc;
`endif

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    err_d  = err_q;
    unique case (1'b1)
      sel_clr: begin
        q_d   = '0;
        err_d = 1'b0;
      end
      sel_pre: q_d = MAX;
      sel_ld: begin
        q_d = in_rng ? bus.din : MAX;
        if (!in_rng) err_d = 1'b1;
      end
      sel_cnt: begin
        q_d    = cnt_nxt;
        wrap_d = wrap_cnt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clear) begin
      q_q    <= '0;
      qnot_q <= '1;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      qnot_q <= ~q_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign bus.q     = q_q;
  assign bus.qnot  = qnot_q;
  assign bus.t_out = q_q ^ q_d;
  assign bus.tc    = tc;
  assign bus.wrap  = wrap_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_tff_updown_counter.sv
// Directed scoreboard bench for tff_updown_counter.
// WIDTH=4, MODULUS=10; honours TFF_UPDOWN_SATURATE_EN.
module tb_tff_updown_counter;

`ifdef TFF_UPDOWN_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [3:0] q;
    logic [3:0] qnot;
    logic       wrap;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic clear;
  int   checks = 0;
  int   errors = 0;

  logic [3:0] mq;
  logic       me;
  bit         known = 1'b0;
  exp_t       sb[$];

  always #5 clk = ~clk;

  tff_updown_counter_if #(.WIDTH(4)) bus ();

  tff_updown_counter #(
    .WIDTH  (4),
    .MODULUS(10)
  ) dut (
    .clk  (clk),
    .clear(clear),
    .bus  (bus.slave)
  );

  task automatic chk4(string tag,
                      logic [3:0] obs,
                      logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b",
             tag, obs, exp);
    end
  endtask

  task automatic chk1(string tag,
                      logic obs,
                      logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b",
             tag, obs, exp);
    end
  endtask

  task automatic apply(string tag,
                       logic c, logic p,
                       logic l, logic e,
                       logic u, logic [3:0] d);
    logic       term, etc, nw, ne;
    logic [3:0] nq;
    exp_t       x;
    clear      = c;
    bus.preset = p;
    bus.load   = l;
    bus.en     = e;
    bus.up     = u;
    bus.din    = d;
    #1;
    term = u ? (mq == 4'd9) : (mq == 4'd0);
    etc  = e & ~l & c & p & term;
    nw   = 1'b0;
    ne   = me;
    if (!c) begin
      nq = 4'd0;
      ne = 1'b0;
    end else if (!p) begin
      nq = 4'd9;
    end else if (l) begin
      nq = (d < 4'd10) ? d : 4'd9;
      ne = me | (d >= 4'd10);
    end else if (e) begin
      nw = etc & ~SAT;
      if (u)
        nq = (mq == 4'd9) ?
             (SAT ? 4'd9 : 4'd0) : mq + 4'd1;
      else
        nq = (mq == 4'd0) ?
             (SAT ? 4'd0 : 4'd9) : mq - 4'd1;
    end else begin
      nq = mq;
    end
    if (known) begin
      chk1({tag, ".tc"}, bus.tc, etc);
      chk4({tag, ".t_out"}, bus.t_out, mq ^ nq);
    end
    sb.push_back('{nq, ~nq, nw, ne});
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk4({tag, ".q"}, bus.q, x.q);
    chk4({tag, ".qnot"}, bus.qnot, x.qnot);
    chk1({tag, ".wrap"}, bus.wrap, x.wrap);
    chk1({tag, ".err"}, bus.err, x.err);
    mq    = nq;
    me    = ne;
    known = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    clear      = 1'b1;
    bus.preset = 1'b1;
    bus.load   = 1'b0;
    bus.en     = 1'b0;
    bus.up     = 1'b0;
    bus.din    = '0;
    mq         = 'x;
    me         = 'x;
    @(posedge clk);
    #1;

    apply("rst", 0, 1, 1, 0, 0, 4'd5);
    chk4("rst.q0", bus.q, 4'd0);
    chk4("rst.qnotF", bus.qnot, 4'b1111);

    for (int i = 0; i < 9; i++)
      apply("up", 1, 1, 0, 1, 1, 4'd0);
    chk4("up.at9", bus.q, 4'd9);
    chk1("up9.tc", bus.tc, 1'b1);
    chk4("up9.t_out", bus.t_out,
         SAT ? 4'b0000 : 4'b1001);
    apply("upwrap", 1, 1, 0, 1, 1, 4'd0);
    chk1("upwrap.pulse", bus.wrap, ~SAT);
    apply("uppost", 1, 1, 0, 1, 1, 4'd0);

    apply("clr", 0, 1, 0, 1, 0, 4'd0);
    apply("dnwrap", 1, 1, 0, 1, 0, 4'd0);
    apply("dnpost", 1, 1, 0, 1, 0, 4'd0);

    apply("ld7", 1, 1, 1, 0, 0, 4'd7);
    apply("ld12", 1, 1, 1, 0, 0, 4'd12);
    chk1("ld12.err", bus.err, 1'b1);
    for (int i = 0; i < 5; i++)
      apply("errhold", 1, 1, 0, 1, 1, 4'd0);
    chk1("errhold.err", bus.err, 1'b1);
    apply("errclr", 0, 1, 0, 1, 1, 4'd0);

    apply("clrpre", 0, 0, 0, 0, 0, 4'd0);
    chk4("clrpre.q", bus.q, 4'd0);
    apply("pre", 1, 0, 1, 1, 1, 4'd12);
    chk4("pre.qnot", bus.qnot, 4'b0110);
    apply("ldvsen", 1, 1, 1, 1, 1, 4'd3);
    chk4("ldvsen.q", bus.q, 4'd3);
    chk1("ldvsen.wrap", bus.wrap, 1'b0);

    apply("pre2", 1, 0, 0, 0, 0, 4'd0);
    apply("dirin", 1, 1, 0, 1, 0, 4'd0);
    chk4("dirin.q", bus.q, 4'd8);

    apply("ld8", 1, 1, 1, 0, 1, 4'd8);
    for (int i = 0; i < 3; i++)
      apply("sat", 1, 1, 0, 1, 1, 4'd0);
    apply("hold", 1, 1, 0, 0, 1, 4'd0);
    apply("hold2", 1, 1, 0, 0, 0, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
